// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose:
//   Shares the single-port data memory between two requesters:
//     port 0 - CPU load/store stage
//     port 1 - debug / DMA loader
//   Arbitration is round-robin on a req/gnt handshake. The memory control
//   pins are driven from registers, so they are stable for the whole ISSUE
//   cycle and the memory (which acts on the falling edge) sees clean inputs.
//   Read data is captured into a per-port response register and flagged with
//   a one-cycle rvalid pulse.
//
//   Transaction flow: IDLE -> ISSUE -> (RESP on a read) -> IDLE
//
// Ports:
//   clk, rst_n              clock (posedge) and asynchronous active-low reset
//   req_x, we_x             request and direction (1 = write) for port x
//   addr_x, wdata_x         word address and write data for port x
//   gnt_x                   one-cycle pulse, high while port x is issued
//   rvalid_x, rdata_x       read response pulse and held read data for port x
//   busy                    high whenever the FSM is not in IDLE
//   mem_addr, mem_wdata     to the memory address / write_data pins
//   mem_read, mem_write     to the memory memread / memwrite pins
//   mem_rdata               from the memory read_data pin
//   lock_0, lock_1          only with DMEM_ARB_LOCK_EN defined: keeps the
//                           current winner as sole owner while it stays high
//
// Configuration:
//   DMEM_ARB_LOCK_EN        define to add the lock_0/lock_1 inputs for
//                           atomic read-modify-write sequences
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              we_0,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic [DATA_W-1:0] wdata_1,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              lock_0,
    input  logic              lock_1,
`endif
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              rvalid_0,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic              last_winner, last_winner_n;
    logic              gnt_0_n, gnt_1_n;
    logic              rvalid_0_n, rvalid_1_n;
    logic [DATA_W-1:0] rdata_0_n, rdata_1_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;
    logic              mem_read_n, mem_write_n;

    // Winner selection, evaluated only in IDLE
    logic              pick_valid;
    logic              pick;
    logic              pick_we;

`ifdef DMEM_ARB_LOCK_EN
    // last_winner is meaningless until the first grant, so a lock raised
    // straight out of reset must not capture the memory for either port.
    logic              owner_valid, owner_valid_n;
    logic              owner_locked;
    assign owner_locked = owner_valid && (last_winner ? lock_1 : lock_0);
`endif

    always_comb begin
        pick_valid = req_0 | req_1;
        // On a tie the port that did not win last time goes first.
        if (req_0 && req_1) begin
            pick = ~last_winner;
        end else begin
            pick = ~req_0;
        end
`ifdef DMEM_ARB_LOCK_EN
        // A locked owner excludes the other port; the other port's req is
        // simply not looked at, so it stays pending until the lock drops.
        if (owner_locked) begin
            pick       = last_winner;
            pick_valid = last_winner ? req_1 : req_0;
        end
`endif
        pick_we = pick ? we_1 : we_0;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n       = state;
        last_winner_n = last_winner;
        gnt_0_n       = 1'b0;
        gnt_1_n       = 1'b0;
        rvalid_0_n    = 1'b0;
        rvalid_1_n    = 1'b0;
        rdata_0_n     = rdata_0;
        rdata_1_n     = rdata_1;
        mem_addr_n    = mem_addr;
        mem_wdata_n   = mem_wdata;
        mem_read_n    = 1'b0;
        mem_write_n   = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        owner_valid_n = owner_valid;
`endif

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    mem_addr_n    = pick ? addr_1 : addr_0;
                    mem_wdata_n   = pick ? wdata_1 : wdata_0;
                    mem_write_n   = pick_we;
                    mem_read_n    = ~pick_we;
                    gnt_0_n       = ~pick;
                    gnt_1_n       = pick;
                    last_winner_n = pick;
                    state_n       = ISSUE;
`ifdef DMEM_ARB_LOCK_EN
                    owner_valid_n = 1'b1;
`endif
                end
            end

            ISSUE: begin
                // mem_read still reflects the direction of the issued access;
                // the memory has already driven mem_rdata on the falling edge.
                if (mem_read) begin
                    if (last_winner) begin
                        rdata_1_n  = mem_rdata;
                        rvalid_1_n = 1'b1;
                    end else begin
                        rdata_0_n  = mem_rdata;
                        rvalid_0_n = 1'b1;
                    end
                    state_n = RESP;
                end else begin
                    state_n = IDLE;
                end
            end

            RESP: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            gnt_0       <= 1'b0;
            gnt_1       <= 1'b0;
            rvalid_0    <= 1'b0;
            rvalid_1    <= 1'b0;
            rdata_0     <= '0;
            rdata_1     <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
        end else begin
            state       <= state_n;
            last_winner <= last_winner_n;
            gnt_0       <= gnt_0_n;
            gnt_1       <= gnt_1_n;
            rvalid_0    <= rvalid_0_n;
            rvalid_1    <= rvalid_1_n;
            rdata_0     <= rdata_0_n;
            rdata_1     <= rdata_1_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            mem_read    <= mem_read_n;
            mem_write   <= mem_write_n;
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_valid <= 1'b0;
        end else begin
            owner_valid <= owner_valid_n;
        end
    end
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_0 = 1'b0, req_1 = 1'b0;
    logic              we_0 = 1'b0, we_1 = 1'b0;
    logic [ADDR_W-1:0] addr_0 = '0, addr_1 = '0;
    logic [DATA_W-1:0] wdata_0 = '0, wdata_1 = '0;
`ifdef DMEM_ARB_LOCK_EN
    logic              lock_0 = 1'b0, lock_1 = 1'b0;
`endif
    logic              gnt_0, gnt_1, rvalid_0, rvalid_1, busy;
    logic [DATA_W-1:0] rdata_0, rdata_1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read, mem_write;
    logic [DATA_W-1:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;
    int wr_count = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_0     (req_0),
        .req_1     (req_1),
        .we_0      (we_0),
        .we_1      (we_1),
        .addr_0    (addr_0),
        .addr_1    (addr_1),
        .wdata_0   (wdata_0),
        .wdata_1   (wdata_1),
`ifdef DMEM_ARB_LOCK_EN
        .lock_0    (lock_0),
        .lock_1    (lock_1),
`endif
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .rvalid_0  (rvalid_0),
        .rvalid_1  (rvalid_1),
        .rdata_0   (rdata_0),
        .rdata_1   (rdata_1),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    // Data memory model: single port, acts on the falling edge
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(negedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (mem_read) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    // One complete transaction on a single port, checks the grant
    task automatic txn(input logic port, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
        if (port) begin req_1 = 1'b1; we_1 = we; addr_1 = a; wdata_1 = d; end
        else      begin req_0 = 1'b1; we_0 = we; addr_0 = a; wdata_0 = d; end
        tick();
        check("txn_gnt", {31'd0, port ? gnt_1 : gnt_0}, 32'd1);
        req_0 = 1'b0;
        req_1 = 1'b0;
        tick();
        if (!we) tick();
    endtask

    initial begin
        int wr_before;

        // Reset state
        #12;
        check("rst_gnt",    {30'd0, gnt_1, gnt_0}, 32'd0);
        check("rst_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd0);
        check("rst_memctl", {30'd0, mem_write, mem_read}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_addr",   {19'd0, mem_addr}, 32'd0);
        check("rst_wdata",  mem_wdata, 32'd0);
        check("rst_rdata0", rdata_0, 32'd0);
        check("rst_rdata1", rdata_1, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Port 0 write 0x12345678 @0, then read back
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 13'h0000; wdata_0 = 32'h12345678;
        tick();
        check("wr_gnt0",   {31'd0, gnt_0}, 32'd1);
        check("wr_memctl", {30'd0, mem_write, mem_read}, 32'd2);
        check("wr_wdata",  mem_wdata, 32'h12345678);
        check("wr_busy",   {31'd0, busy}, 32'd1);
        req_0 = 1'b0;
        tick();
        check("wr_done_memctl", {30'd0, mem_write, mem_read}, 32'd0);
        check("wr_done_gnt",    {31'd0, gnt_0}, 32'd0);
        check("wr_done_busy",   {31'd0, busy}, 32'd0);
        check("wr_mem",         mem[0], 32'h12345678);
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 13'h0000;
        tick();
        check("rd_gnt0",   {31'd0, gnt_0}, 32'd1);
        check("rd_memctl", {30'd0, mem_write, mem_read}, 32'd1);
        req_0 = 1'b0;
        tick();
        check("rd_rvalid0", {31'd0, rvalid_0}, 32'd1);
        check("rd_rdata0",  rdata_0, 32'h12345678);
        check("rd_resp_memctl", {30'd0, mem_write, mem_read}, 32'd0);
        tick();
        check("rd_rvalid0_drop", {31'd0, rvalid_0}, 32'd0);
        check("rd_rdata0_hold",  rdata_0, 32'h12345678);

        // Preload two words, then reset and contend with two held reads
        txn(1'b0, 1'b1, 13'h0005, 32'hA5A5_0005);
        txn(1'b1, 1'b1, 13'h0006, 32'h5A5A_0006);
        do_reset();
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 13'h0005;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 13'h0006;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_gnt", {30'd0, gnt_1, gnt_0}, (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            check("rr_rvalid", {30'd0, rvalid_1, rvalid_0}, (i % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_rdata", (i % 2 == 0) ? rdata_0 : rdata_1,
                  (i % 2 == 0) ? 32'hA5A5_0005 : 32'h5A5A_0006);
            tick();
        end
        req_0 = 1'b0;
        req_1 = 1'b0;

        // Make port 0 the last winner, then write(port1)/read(port0) same address
        txn(1'b0, 1'b0, 13'h0005, 32'd0);
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 13'h1FFF; wdata_1 = 32'hDEADBEEF;
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 13'h1FFF;
        tick();
        check("ord_first_gnt", {30'd0, gnt_1, gnt_0}, 32'd2);
        check("ord_first_wr",  {30'd0, mem_write, mem_read}, 32'd2);
        check("ord_addr",      {19'd0, mem_addr}, 32'h1FFF);
        req_1 = 1'b0;
        tick();
        tick();
        check("ord_second_gnt", {30'd0, gnt_1, gnt_0}, 32'd1);
        req_0 = 1'b0;
        tick();
        check("ord_rvalid0", {31'd0, rvalid_0}, 32'd1);
        check("ord_rdata0",  rdata_0, 32'hDEADBEEF);
        tick();

        // Reset asserted during ISSUE of a write
        check("pre_rst_rdata1", rdata_1, 32'h5A5A_0006);
        wr_before = wr_count;
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 13'h0020; wdata_0 = 32'hCAFEF00D;
        tick();
        check("mid_issue_wr", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_memwr", {30'd0, mem_write, mem_read}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy}, 32'd0);
        check("mid_rst_gnt",   {30'd0, gnt_1, gnt_0}, 32'd0);
        check("mid_rst_rdata1", rdata_1, 32'd0);
        check("mid_rst_rdata0", rdata_0, 32'd0);
        req_0 = 1'b0;
        #4;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_quiet", {27'd0, busy, gnt_1, gnt_0, rvalid_1, rvalid_0}, 32'd0);
        end
        check("lost_write", wr_count - wr_before, 32'd0);

`ifdef DMEM_ARB_LOCK_EN
        // Locked read-modify-write by port 0 while port 1 waits
        do_reset();
        lock_0 = 1'b1;
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 13'h0010;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 13'h0011;
        tick();
        check("lk_rd_gnt", {30'd0, gnt_1, gnt_0}, 32'd1);
        req_0 = 1'b0;
        tick();
        tick();
        tick();
        check("lk_hold_gnt",  {30'd0, gnt_1, gnt_0}, 32'd0);
        check("lk_hold_busy", {31'd0, busy}, 32'd0);
        req_0 = 1'b1; we_0 = 1'b1; wdata_0 = 32'h0000_0BAD;
        tick();
        check("lk_wr_gnt", {30'd0, gnt_1, gnt_0}, 32'd1);
        req_0 = 1'b0;
        tick();
        tick();
        check("lk_still_held", {30'd0, gnt_1, gnt_0}, 32'd0);
        lock_0 = 1'b0;
        tick();
        check("lk_release_gnt", {30'd0, gnt_1, gnt_0}, 32'd2);
        req_1 = 1'b0;
        tick();
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
